sram16_responder: RTL and testbench

Bus responder that lets the CPU's 32-bit memory bus reach an external asynchronous 16-bit SRAM. It accepts read/write requests with byte enables and splits each 32-bit access into at most two 16-bit SRAM cycles, one per half-word. It holds `waitrequest` high until the access is complete. It sits on the responder side of the bus, behind the address decoder, opposite the CPU.

---
 rtl/sram16_responder.sv | 181 ++++++++++++++++++
 tb/tb_sram16_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram16_responder.sv
// Bus responder bridging a 32-bit memory bus onto an asynchronous 16-bit SRAM.
// Each 32-bit access becomes up to two half-word SRAM phases (LO then HI);
// waitrequest is held until the access reaches DONE.
module sram16_responder #(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-2:0] word_q, word_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           dq_out_q, dq_out_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  lb_n_q, lb_n_d;
  logic                  ub_n_q, ub_n_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_WIDTH+1], address[1:0]};

  // State, request latches, read data and registered SRAM pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
    end
  end

  // Next-state: request acceptance, phase counting, read-data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (read | write) begin
          wr_d    = write;
          be_d    = byteenable;
          wdata_d = writedata;
          word_d  = address[ADDR_WIDTH:2];
          rdata_d = '0;
          cnt_d   = 4'd1;
          if (|byteenable[1:0])      state_d = LO;
          else if (|byteenable[3:2]) state_d = HI;
          else                       state_d = DONE;
        end
      end
      LO: begin
        if (cnt_q == W_LAST) begin
          if (!wr_q)
            rdata_d[15:0] = sram_dq_in & {{8{be_q[1]}}, {8{be_q[0]}}};
          cnt_d   = 4'd1;
          state_d = (|be_q[3:2]) ? HI : DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (cnt_q == W_LAST) begin
          if (!wr_q)
            rdata_d[31:16] = sram_dq_in & {{8{be_q[3]}}, {8{be_q[2]}}};
          cnt_d   = 4'd1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pin values are derived from the upcoming state so the pins are
  // registered yet line up with the phase they belong to.
  always_comb begin
    addr_d   = '0;
    dq_out_d = '0;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    if (state_d == LO || state_d == HI) begin
      ce_n_d = 1'b0;
      if (state_d == LO) begin
        addr_d   = {word_d, 1'b0};
        lb_n_d   = ~be_d[0];
        ub_n_d   = ~be_d[1];
        dq_out_d = wdata_d[15:0];
      end else begin
        addr_d   = {word_d, 1'b1};
        lb_n_d   = ~be_d[2];
        ub_n_d   = ~be_d[3];
        dq_out_d = wdata_d[31:16];
      end
      if (wr_d) begin
        dq_oe_d = 1'b1;
        we_n_d  = (cnt_d == W_LAST);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  assign waitrequest = (read | write) && (state_q != DONE);
  assign readdata    = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_lb_n   = lb_n_q;
  assign sram_ub_n   = ub_n_q;

endmodule

// File: tb/tb_sram16_responder.sv
// Scoreboard bench for sram16_responder with a behavioural 16-bit SRAM model.
module tb_sram16_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram16_responder #(.ADDR_WIDTH(20), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .waitrequest(waitrequest), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // SRAM model
  logic [15:0] mem [logic [19:0]];

  function automatic logic [15:0] memrd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always_comb begin
    sram_dq_in = 16'h0000;
    if (!sram_ce_n && !sram_oe_n) sram_dq_in = memrd(sram_addr);
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      logic [15:0] v;
      v = memrd(sram_addr);
      if (!sram_lb_n) v[7:0]  = sram_dq_out[7:0];
      if (!sram_ub_n) v[15:8] = sram_dq_out[15:8];
      mem[sram_addr] = v;
    end
  end

  // Strobe activity counters, cleared by the driver at each request
  int ce_lo, oe_lo, we_lo, lb_lo, ub_lo;
  always @(negedge clk) begin
    if (!sram_ce_n) ce_lo++;
    if (!sram_oe_n) oe_lo++;
    if (!sram_we_n) we_lo++;
    if (!sram_ce_n && !sram_lb_n) lb_lo++;
    if (!sram_ce_n && !sram_ub_n) ub_lo++;
  end

  // Scoreboard
  typedef struct { logic [31:0] rd; int cyc; } exp_t;
  exp_t exp_q[$];
  int   cyc_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n || !(read || write)) begin
      cyc_cnt = 0;
    end else if (!waitrequest) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("readdata", readdata, e.rd);
        check("done_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
      cyc_cnt = 0;
    end else begin
      cyc_cnt++;
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int cyc, input logic [31:0] exp_rd);
    logic done;
    exp_q.push_back('{rd: exp_rd, cyc: cyc});
    ce_lo = 0; oe_lo = 0; we_lo = 0; lb_lo = 0; ub_lo = 0;
    read = r; write = w; address = a; writedata = wd; byteenable = be;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!waitrequest) begin done = 1'b1; break; end
    end
    check("completed", 32'(done), 32'd1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    logic hit;
    mem[20'd24] = 16'h1111;
    reset_n = 1'b0; read = 1'b1; write = 1'b0;
    address = '0; writedata = '0; byteenable = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_waitreq", 32'(waitrequest), 32'd1);
    check("rst_readdata", readdata, 32'd0);
    check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    read = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 5, 32'h0);
    check("wr_we_cycles", 32'(we_lo), 32'd2);
    check("wr_oe_cycles", 32'(oe_lo), 32'd0);
    check("wr_mem8", 32'(memrd(20'd8)), 32'h0000BEEF);
    check("wr_mem9", 32'(memrd(20'd9)), 32'h0000DEAD);

    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b0100, 3, 32'h00AD0000);
    check("rdhi_ce_cycles", 32'(ce_lo), 32'd2);
    check("rdhi_lb_cycles", 32'(lb_lo), 32'd2);
    check("rdhi_ub_cycles", 32'(ub_lo), 32'd0);
    check("rdhi_we_cycles", 32'(we_lo), 32'd0);

    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1, 32'h0);
    check("be0_ce_cycles", 32'(ce_lo), 32'd0);

    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF);
    check("rd32_oe_cycles", 32'(oe_lo), 32'd4);

    access(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 5, 32'h0);
    check("rw_we_cycles", 32'(we_lo), 32'd2);
    check("rw_oe_cycles", 32'(oe_lo), 32'd0);
    check("rw_mem16", 32'(memrd(20'd16)), 32'h00005678);
    check("rw_mem17", 32'(memrd(20'd17)), 32'h00001234);

    access(1'b0, 1'b1, 32'h30, 32'h0000AB00, 4'b0010, 3, 32'h0);
    check("wrub_mem24", 32'(memrd(20'd24)), 32'h0000AB11);
    check("wrub_lb_cycles", 32'(lb_lo), 32'd0);

    access(1'b1, 1'b0, 32'h30, 32'h0, 4'b0011, 3, 32'h0000AB11);

    // Reset during the HI phase of a write
    write = 1'b1; address = 32'h40; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!sram_ce_n && sram_addr[0]) begin hit = 1'b1; break; end
    end
    check("reached_hi", 32'(hit), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    write = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
